// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it into a 32x32 register file
// with x0 hardwired to zero, and counts commits. Define WB_BYPASS_EN for same-cycle read bypass.
module wb_regfile #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_reg,
    input  logic                MemtoRegin,
    input  logic                RegWritein,
    input  logic [31:0]         MEMResultin,
    input  logic [31:0]         ALUResultin,
    input  logic [4:0]          rdin,
    input  logic [4:0]          rs,
    input  logic [4:0]          rt,
    output logic [31:0]         rsdata,
    output logic [31:0]         rtdata,
    output logic [31:0]         wbdata,
    output logic                wbvalid,
    output logic [RETIRE_W-1:0] retire_cnt
);

    localparam int unsigned NREGS = 32;

    logic [31:0]         regs_q [NREGS-1:1];
    logic [RETIRE_W-1:0] cnt_q;
    logic [RETIRE_W-1:0] cnt_d;

    assign wbdata     = MemtoRegin ? MEMResultin : ALUResultin;
    assign wbvalid    = en_reg && RegWritein && (rdin != 5'd0);
    assign cnt_d      = cnt_q + RETIRE_W'(1);
    assign retire_cnt = cnt_q;

    // Reset has priority over a commit presented in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                regs_q[i] <= 32'h0;
            end
            cnt_q <= '0;
        end else if (wbvalid) begin
            regs_q[rdin] <= wbdata;
            cnt_q        <= cnt_d;
        end
    end

    // Read ports resolve independently; index 0 always reads zero
    always_comb begin
        rsdata = 32'h0;
        if (rs != 5'd0) begin
`ifdef WB_BYPASS_EN
            if (wbvalid && (rs == rdin)) rsdata = wbdata;
            else                         rsdata = regs_q[rs];
`else
            rsdata = regs_q[rs];
`endif
        end
    end

    always_comb begin
        rtdata = 32'h0;
        if (rt != 5'd0) begin
`ifdef WB_BYPASS_EN
            if (wbvalid && (rt == rdin)) rtdata = wbdata;
            else                         rtdata = regs_q[rt];
`else
            rtdata = regs_q[rt];
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboarded bench for wb_regfile: directed cases then random traffic against an array model.
module tb_wb_regfile;

    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst, en_reg, MemtoRegin, RegWritein;
    logic [31:0]   MEMResultin, ALUResultin;
    logic [4:0]    rdin, rs, rt;
    logic [31:0]   rsdata, rtdata, wbdata;
    logic          wbvalid;
    logic [RW-1:0] retire_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .en_reg(en_reg), .MemtoRegin(MemtoRegin),
        .RegWritein(RegWritein), .MEMResultin(MEMResultin), .ALUResultin(ALUResultin),
        .rdin(rdin), .rs(rs), .rt(rt), .rsdata(rsdata), .rtdata(rtdata),
        .wbdata(wbdata), .wbvalid(wbvalid), .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic [31:0]   rsd, rtd, wbd;
        logic          wbv;
        logic [RW-1:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mregs [32];
    int unsigned mcnt;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endfunction

    // Monitor: compare DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsdata",     rsdata,            e.rsd);
                check("rtdata",     rtdata,            e.rtd);
                check("wbdata",     wbdata,            e.wbd);
                check("wbvalid",    32'(wbvalid),      32'(e.wbv));
                check("retire_cnt", 32'(retire_cnt),   32'(e.cnt));
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wv, input logic [31:0] wbd);
        if (idx == 5'd0) return 32'h0;
        if (BYP && wv && idx == rdin) return wbd;
        return mregs[idx];
    endfunction

    // One clock: predict this cycle's outputs, then apply the edge to the model
    task automatic step(input bit chk);
        exp_t e;
        e.wbd = MemtoRegin ? MEMResultin : ALUResultin;
        e.wbv = en_reg && RegWritein && rdin != 5'd0;
        e.rsd = model_read(rs, e.wbv, e.wbd);
        e.rtd = model_read(rt, e.wbv, e.wbd);
        e.cnt = RW'(mcnt % (1 << RW));
        if (chk) sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mcnt = 0;
        end else if (e.wbv) begin
            mregs[rdin] = e.wbd;
            mcnt++;
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic en, input logic m2r, input logic rw,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        rst = r; en_reg = en; MemtoRegin = m2r; RegWritein = rw;
        MEMResultin = mem; ALUResultin = alu; rdin = rd; rs = a; rt = b;
        step(1'b1);
    endtask

    initial begin
        mcnt = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        rst = 1'b1; en_reg = 1'b0; MemtoRegin = 1'b0; RegWritein = 1'b0;
        MEMResultin = 32'h0; ALUResultin = 32'h0; rdin = 5'd0; rs = 5'd0; rt = 5'd0;
        step(1'b0);
        step(1'b0);

        // Reset with prior contents, and a write presented during reset is dropped
        drive(0, 1, 0, 1, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        drive(1, 1, 0, 1, 32'h0, 32'h0BAD_0BAD, 5'd6, 5'd5, 5'd6);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);

        // Writeback mux: memory path then ALU path
        drive(0, 1, 1, 1, 32'h1234_5678, 32'hFFFF_0000, 5'd7, 5'd7, 5'd0);
        drive(0, 1, 0, 1, 32'h1234_5678, 32'hFFFF_0000, 5'd8, 5'd7, 5'd8);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd8);

        // x0 protection and stall
        drive(0, 1, 0, 1, 32'h0, 32'hAAAA_AAAA, 5'd0, 5'd0, 5'd0);
        drive(0, 0, 0, 1, 32'h0, 32'h55, 5'd9, 5'd9, 5'd0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);

        // Same-cycle read of the register being written
        drive(0, 1, 0, 1, 32'h0, 32'h1111_2222, 5'd3, 5'd0, 5'd0);
        drive(0, 1, 1, 1, 32'hCAFE_F00D, 32'h0, 5'd3, 5'd3, 5'd3);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);

        // Counter wrap: 17 consecutive commits
        for (int k = 0; k < 17; k++)
            drive(0, 1, 0, 1, 32'h0, 32'h100 + 32'(k), 5'((k % 31) + 1), 5'(k), 5'((k + 1) % 32));
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd17);

        // Random traffic, with reads biased toward the destination register
        for (int k = 0; k < 400; k++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 3) != 0), $urandom, $urandom, rd,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
